// File: rtl/pcie_ipcfg_seq.sv
// Applies a table of {core, offset, data} register writes to PCIE_CORE LMMI targets,
// optionally reading each one back and comparing, with per-phase timeout and error capture.
module pcie_ipcfg_seq #(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned OFFSET_W  = 9,
  parameter int unsigned DATA_W    = 8,
  parameter bit          VERIFY    = 1'b1,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned IDX_W    = $clog2(DEPTH),
  localparam int unsigned ENTRY_W  = CORE_W + OFFSET_W + DATA_W
) (
  input  logic                          lmmi_clk,
  input  logic                          lmmi_resetn,
  input  logic                          cfg_wr_en,
  input  logic [IDX_W-1:0]              cfg_wr_addr,
  input  logic [ENTRY_W-1:0]            cfg_wr_data,
  input  logic                          start,
  input  logic [IDX_W:0]                count,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [IDX_W-1:0]              err_idx,
  output logic [1:0]                    err_code,
  output logic [NUM_CORES-1:0]          lmmi_request,
  output logic                          lmmi_wr_rdn,
  output logic [OFFSET_W-1:0]           lmmi_offset,
  output logic [DATA_W-1:0]             lmmi_wdata,
  input  logic [NUM_CORES-1:0]          lmmi_ready,
  input  logic [NUM_CORES*DATA_W-1:0]   lmmi_rdata,
  input  logic [NUM_CORES-1:0]          lmmi_rdata_valid
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWrReq, StRdReq, StRdWait, StNext, StErr
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W:0]       count_q, count_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     err_idx_q, err_idx_d;
  logic [1:0]           err_code_q, err_code_d;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   ent_q;
  logic [CORE_W-1:0]    ent_core, core_sel;
  logic [OFFSET_W-1:0]  ent_off;
  logic [DATA_W-1:0]    ent_data, sel_rdata;
  logic [NUM_CORES-1:0] sel_oh;
  logic                 sel_ready, sel_valid;

  always_ff @(posedge lmmi_clk) begin
    if (cfg_wr_en && !busy) mem[cfg_wr_addr] <= cfg_wr_data;
  end

  // Entry is captured once in FETCH so the LMMI fields stay frozen for the whole entry.
  always_ff @(posedge lmmi_clk or negedge lmmi_resetn) begin
    if (!lmmi_resetn) begin
      ent_q <= '0;
    end else if (state_q == StFetch) begin
      ent_q <= mem[idx_q];
    end
  end

  assign ent_core = ent_q[ENTRY_W-1 -: CORE_W];
  assign ent_off  = ent_q[DATA_W +: OFFSET_W];
  assign ent_data = ent_q[DATA_W-1:0];
  assign core_sel = CORE_W'(32'(ent_core) % NUM_CORES);
  assign sel_oh   = NUM_CORES'(1) << core_sel;
  assign sel_ready = |(lmmi_ready & sel_oh);
  assign sel_valid = |(lmmi_rdata_valid & sel_oh);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (core_sel == CORE_W'(i)) sel_rdata = lmmi_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d      = 1'b0;
          err_idx_d  = '0;
          err_code_d = 2'b00;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StFetch;
            idx_d   = '0;
            count_d = count;
          end
        end
      end
      StFetch: begin
        state_d = StWrReq;
        tmo_d   = '0;
      end
      StWrReq, StRdReq: begin
        if (sel_ready) begin
          tmo_d = '0;
          if (state_q == StRdReq) state_d = StRdWait;
          else                    state_d = VERIFY ? StRdReq : StNext;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = StErr;
          err_code_d = 2'b01;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StRdWait: begin
        if (sel_valid) begin
          if (sel_rdata == ent_data) begin
            state_d = StNext;
          end else begin
            state_d    = StErr;
            err_code_d = 2'b10;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = StErr;
          err_code_d = 2'b01;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StNext: begin
        idx_d = idx_q + IDX_W'(1);
        if ((IDX_W+1)'(idx_q) + (IDX_W+1)'(1) == count_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StErr: begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge lmmi_clk or negedge lmmi_resetn) begin
    if (!lmmi_resetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign err_idx      = err_idx_q;
  assign err_code     = err_code_q;
  assign lmmi_request = (state_q == StWrReq || state_q == StRdReq) ? sel_oh : '0;
  assign lmmi_wr_rdn  = (state_q == StWrReq);
  assign lmmi_offset  = ent_off;
  assign lmmi_wdata   = ent_data;

endmodule
